// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: 10b->8b decode, control-token detection and word
// alignment search that steers the upstream deserializer via bitslip.
module tmds_channel_decoder #(
  parameter int unsigned TOKEN_RUN = 32,
  parameter int unsigned WINDOW    = 2048,
  parameter int unsigned SLIP_WAIT = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] symbol_in,
  output logic [7:0] data_out,
  output logic [1:0] ctrl_out,
  output logic       de_out,
  output logic       locked,
  output logic       bitslip
);

  localparam int unsigned WIN_W = $clog2(WINDOW);
  localparam int unsigned RUN_W = 8;
  localparam int unsigned SET_W = 8;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_SLIP_WAIT,
    ST_LOCKED
  } state_t;

  state_t             state_q, state_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [RUN_W-1:0]   run_cnt;
  logic               locked_d, bitslip_d;

  logic               tok_now;
  logic [1:0]         tok_ctrl_now;
  logic [9:0]         s1_sym;
  logic               s1_tok;
  logic [1:0]         s1_ctrl;
  logic [7:0]         d, dec;
  logic               run_hit, win_expired;

  always_comb begin
    tok_now      = 1'b1;
    tok_ctrl_now = 2'b00;
    unique case (symbol_in)
      10'b1101010100: tok_ctrl_now = 2'b00;
      10'b0010101011: tok_ctrl_now = 2'b01;
      10'b0101010100: tok_ctrl_now = 2'b10;
      10'b1010101011: tok_ctrl_now = 2'b11;
      default:        tok_now      = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_sym  <= '0;
      s1_tok  <= 1'b0;
      s1_ctrl <= '0;
    end else begin
      s1_sym  <= symbol_in;
      s1_tok  <= tok_now;
      s1_ctrl <= tok_ctrl_now;
    end
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    d      = s1_sym[9] ? ~s1_sym[7:0] : s1_sym[7:0];
    dec    = '0;
    dec[0] = d[0];
    for (int unsigned i = 1; i < 8; i++) begin
      dec[i] = s1_sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
      ctrl_out <= '0;
      de_out   <= 1'b0;
    end else if (!locked) begin
      data_out <= '0;
      ctrl_out <= '0;
      de_out   <= 1'b0;
    end else if (s1_tok) begin
      de_out   <= 1'b0;
      ctrl_out <= s1_ctrl;
    end else begin
      de_out   <= 1'b1;
      data_out <= dec;
    end
  end

  // run_hit fires only on the 31->32 step, so a saturated run cannot retrigger.
  assign run_hit     = s1_tok && (state_q != ST_SLIP_WAIT) &&
                       (run_cnt == RUN_W'(TOKEN_RUN - 1));
  assign win_expired = (win_q == WIN_W'(WINDOW - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt <= '0;
    end else if (state_q == ST_SLIP_WAIT || !s1_tok) begin
      run_cnt <= '0;
    end else if (run_cnt != RUN_W'(TOKEN_RUN)) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    settle_d  = settle_q;
    locked_d  = locked;
    bitslip_d = 1'b0;
    unique case (state_q)
      ST_SEARCH: begin
        locked_d = 1'b0;
        if (run_hit) begin
          state_d  = ST_LOCKED;
          locked_d = 1'b1;
          win_d    = '0;
        end else if (win_expired) begin
          state_d   = ST_SLIP_WAIT;
          bitslip_d = 1'b1;
          win_d     = '0;
          settle_d  = '0;
        end else begin
          win_d = win_q + 1'b1;
        end
      end
      // The pulse cycle itself plus SLIP_WAIT settle cycles are ignored.
      ST_SLIP_WAIT: begin
        if (settle_q == SET_W'(SLIP_WAIT)) begin
          state_d  = ST_SEARCH;
          win_d    = '0;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (run_hit) begin
          win_d = '0;
        end else if (win_expired) begin
          state_d  = ST_SEARCH;
          locked_d = 1'b0;
          win_d    = '0;
        end else begin
          win_d = win_q + 1'b1;
        end
      end
      default: begin
        state_d  = ST_SEARCH;
        locked_d = 1'b0;
        win_d    = '0;
        settle_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_SEARCH;
      win_q    <= '0;
      settle_q <= '0;
      locked   <= 1'b0;
      bitslip  <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      settle_q <= settle_d;
      locked   <= locked_d;
      bitslip  <= bitslip_d;
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: decode, lock/refresh/loss timing,
// bitslip search against a rotating deserializer model, and async reset.
module tb_tmds_channel_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] symbol_in;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       de_out;
  logic       locked;
  logic       bitslip;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int slip_cnt = 0;
  int unsigned rot = 0;
  bit use_serdes = 1'b0;
  logic [9:0] tx_prev = '0;
  int disp = 0;

  tmds_channel_decoder #(
    .TOKEN_RUN(32),
    .WINDOW(2048),
    .SLIP_WAIT(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .symbol_in(symbol_in),
    .data_out(data_out),
    .ctrl_out(ctrl_out),
    .de_out(de_out),
    .locked(locked),
    .bitslip(bitslip)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One symbol per clock; optional deserializer model slips one bit per pulse.
  task automatic send(input logic [9:0] tx);
    logic [19:0] cat;
    cat = {tx, tx_prev};
    symbol_in = use_serdes ? 10'(cat >> rot) : tx;
    tx_prev = tx;
    @(posedge clk);
    #1;
    cyc++;
    if (bitslip) begin
      slip_cnt++;
      if (use_serdes) rot = (rot + 1) % 10;
    end
  endtask

  task automatic encode(input logic [7:0] dv, output logic [9:0] q);
    int n1, n1q, n0q;
    logic [8:0] qm;
    n1 = $countones(dv);
    qm = '0;
    qm[0] = dv[0];
    if (n1 > 4 || (n1 == 4 && dv[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ dv[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ dv[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (disp == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      if (qm[8] == 1'b0) disp += n0q - n1q;
      else disp += n1q - n0q;
    end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      disp += 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      disp += -2 * int'(!qm[8]) + n1q - n0q;
    end
  endtask

  function automatic bit is_tok(input logic [9:0] v);
    return (v == 10'h354) || (v == 10'h0AB) || (v == 10'h154) || (v == 10'h2AB);
  endfunction

  initial begin
    logic [9:0] q;
    logic [9:0] v;
    int hit_cyc, fall_cyc, slip_cyc, last_slip, idx;

    // Reset state
    reset_n = 1'b0;
    symbol_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", data_out, 0);
    check("rst_ctrl", ctrl_out, 0);
    check("rst_de", de_out, 0);
    check("rst_locked", locked, 0);
    check("rst_bitslip", bitslip, 0);
    reset_n = 1'b1;

    // 1: aligned stream, lock two cycles after the 32nd token
    for (int k = 1; k <= 160; k++) begin
      send(10'h354);
      if (k == 32) check("t1_unlocked_at_32", locked, 0);
      if (k == 33) begin
        check("t1_locked_at_33", locked, 1);
        check("t1_gated_de", de_out, 0);
      end
    end
    for (int k = 1; k <= 640; k++) begin
      send(10'h100);
      if (k == 1) check("t1_de_latency", de_out, 0);
      if (k == 2) begin
        check("t1_de_data", de_out, 1);
        check("t1_data_00", data_out, 8'h00);
      end
    end
    for (int k = 1; k <= 160; k++) begin
      send(10'h354);
      if (k == 2) begin
        check("t1_blank_de", de_out, 0);
        check("t1_blank_ctrl", ctrl_out, 2'b00);
      end
    end
    for (int k = 1; k <= 640; k++) send(10'h100);
    check("t1_still_locked", locked, 1);

    // 2: data decode and 2-cycle latency
    send(10'h2FF);
    check("t2_hold_prev", data_out, 8'h00);
    send(10'h100);
    check("t2_2ff", data_out, 8'hFE);
    check("t2_2ff_de", de_out, 1);
    send(10'h100);
    check("t2_100", data_out, 8'h00);
    disp = 0;
    for (int vv = 0; vv < 256; vv++) begin
      encode(8'(vv), q);
      send(q);
      if (vv >= 1) check("t2_roundtrip", data_out, 32'(vv - 1));
    end
    send(10'h354);
    check("t2_roundtrip_last", data_out, 8'hFF);

    // 3: control tokens in 32-runs; data_out holds last byte in blanking
    for (int k = 1; k <= 31; k++) send(10'h354);
    check("t3_ctrl00", ctrl_out, 2'b00);
    check("t3_de00", de_out, 0);
    check("t3_data_hold", data_out, 8'hFF);
    for (int k = 1; k <= 32; k++) send(10'h0AB);
    check("t3_ctrl01", ctrl_out, 2'b01);
    for (int k = 1; k <= 32; k++) send(10'h154);
    check("t3_ctrl10", ctrl_out, 2'b10);
    for (int k = 1; k <= 32; k++) send(10'h2AB);
    check("t3_ctrl11", ctrl_out, 2'b11);
    check("t3_de11", de_out, 0);
    send(10'h100);
    send(10'h100);
    check("t3_ctrl_hold", ctrl_out, 2'b11);
    check("t3_de_back", de_out, 1);
    check("t3_locked", locked, 1);

    // 5: lock loss after a window without refresh, then first slip a window later
    send(10'h100);
    hit_cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      send(10'h354);
      if (k == 33) hit_cyc = cyc;
    end
    check("t5_locked_before", locked, 1);
    slip_cnt = 0;
    fall_cyc = -1;
    slip_cyc = -1;
    for (int n = 0; n < 6000 && slip_cyc < 0; n++) begin
      do v = 10'($urandom_range(0, 1023)); while (is_tok(v));
      send(v);
      if (fall_cyc < 0 && !locked) begin
        fall_cyc = cyc;
        check("t5_fall_delay", cyc - hit_cyc, 2048);
        check("t5_no_slip_at_drop", bitslip, 0);
        check("t5_no_slip_before_drop", slip_cnt, 0);
      end else if (fall_cyc >= 0 && cyc == fall_cyc + 1) begin
        check("t5_gated_de", de_out, 0);
        check("t5_gated_data", data_out, 0);
      end
      if (bitslip && slip_cyc < 0) slip_cyc = cyc;
    end
    check("t5_fall_seen", fall_cyc >= 0, 1);
    check("t5_first_slip", slip_cyc - fall_cyc, 2048);

    // 6: async reset mid-line while locked, then relock
    for (int k = 1; k <= 60; k++) send(10'h2AB);
    check("t6_locked", locked, 1);
    disp = 0;
    for (int k = 1; k <= 3; k++) begin
      encode(8'h5A, q);
      send(q);
    end
    check("t6_data_pre", data_out, 8'h5A);
    check("t6_ctrl_pre", ctrl_out, 2'b11);
    reset_n = 1'b0;
    #2;
    check("t6_rst_data", data_out, 0);
    check("t6_rst_ctrl", ctrl_out, 0);
    check("t6_rst_de", de_out, 0);
    check("t6_rst_locked", locked, 0);
    check("t6_rst_bitslip", bitslip, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      send(10'h354);
      if (k == 32) check("t6_unlocked_at_32", locked, 0);
      if (k == 33) check("t6_relocked_at_33", locked, 1);
    end

    // 4: stream rotated by 3 bits, deserializer model slips on each pulse
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    use_serdes = 1'b1;
    rot = 3;
    tx_prev = '0;
    slip_cnt = 0;
    last_slip = -1;
    idx = 0;
    for (int n = 0; n < 25000 && !locked; n++) begin
      send((idx % 800) < 160 ? 10'h354 : 10'h100);
      idx++;
      if (bitslip) begin
        if (last_slip >= 0) check("t4_slip_spacing", cyc - last_slip, 2057);
        last_slip = cyc;
      end
    end
    check("t4_locked", locked, 1);
    check("t4_slip_count", slip_cnt, 7);
    for (int n = 0; n < 1000; n++) begin
      send((idx % 800) < 160 ? 10'h354 : 10'h100);
      idx++;
    end
    check("t4_no_extra_slips", slip_cnt, 7);
    check("t4_stays_locked", locked, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
